fetch_unit: RTL and testbench

Instruction fetch stage: owns the program counter, issues in-order requests to instruction memory over a valid/ready port, and buffers returned instructions for decode. It consumes the taken-branch/jump redirect produced in execute by the branch comparator. On a redirect it reloads the PC, flushes its own buffer and discards wrong-path responses still in flight.

---
 rtl/fetch_unit.sv | 155 +++++++++++++++
 tb/tb_fetch_unit.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, issues credit-limited in-order memory requests and
// buffers returned instructions for decode; redirects flush and drop wrong-path responses.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned DEPTH    = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  output logic        if_valid,
  input  logic        if_ready,
  output logic [31:0] if_pc,
  output logic [31:0] if_instr
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH + 1);

  typedef logic [AW-1:0] ptr_t;
  typedef logic [CW-1:0] cnt_t;
  typedef logic [CW:0]   occ_t;

  logic [31:0] pc_q, pc_d;

  // PCs of accepted requests whose responses will be kept.
  logic [31:0] pend_pc_q [DEPTH];
  ptr_t        pend_wr_q, pend_wr_d;
  ptr_t        pend_rd_q, pend_rd_d;

  logic [31:0] fifo_pc_q    [DEPTH];
  logic [31:0] fifo_instr_q [DEPTH];
  ptr_t        fifo_wr_q, fifo_wr_d;
  ptr_t        fifo_rd_q, fifo_rd_d;
  cnt_t        fifo_count_q, fifo_count_d;

  cnt_t        in_flight_q, in_flight_d;
  cnt_t        drop_cnt_q, drop_cnt_d;

  occ_t        occupancy;
  logic        req_fire;
  logic        rsp_push;
  logic        if_pop;
  cnt_t        rsp_dec;
  logic [31:0] redirect_target;
  logic        unused_redirect_lsb;

  assign redirect_target     = {redirect_pc[31:2], 2'b00};
  assign unused_redirect_lsb = ^redirect_pc[1:0];

  // Credits come from registered counts only, so if_ready never reaches imem_req_valid.
  assign occupancy      = occ_t'(in_flight_q) + occ_t'(fifo_count_q);
  assign imem_req_valid = !rst && !redirect_valid && (occupancy < occ_t'(DEPTH));
  assign imem_req_addr  = pc_q;
  assign req_fire       = imem_req_valid && imem_req_ready;

  assign rsp_push = imem_rsp_valid && !redirect_valid && (drop_cnt_q == '0);
  assign rsp_dec  = cnt_t'(imem_rsp_valid);

  assign if_valid = (fifo_count_q != '0);
  assign if_pop   = if_valid && if_ready;

  always_comb begin
    if_pc    = '0;
    if_instr = '0;
    if (if_valid) begin
      if_pc    = fifo_pc_q[fifo_rd_q];
      if_instr = fifo_instr_q[fifo_rd_q];
    end
  end

  always_comb begin
    pc_d         = pc_q;
    pend_wr_d    = pend_wr_q;
    pend_rd_d    = pend_rd_q;
    fifo_wr_d    = fifo_wr_q;
    fifo_rd_d    = fifo_rd_q;
    fifo_count_d = fifo_count_q;
    in_flight_d  = in_flight_q;
    drop_cnt_d   = drop_cnt_q;

    if (redirect_valid) begin
      // Everything still outstanding is wrong-path; a response this cycle is already gone.
      pc_d         = redirect_target;
      pend_wr_d    = '0;
      pend_rd_d    = '0;
      fifo_wr_d    = '0;
      fifo_rd_d    = '0;
      fifo_count_d = '0;
      in_flight_d  = in_flight_q - rsp_dec;
      drop_cnt_d   = in_flight_q - rsp_dec;
    end else begin
      if (req_fire) begin
        pc_d      = pc_q + 32'd4;
        pend_wr_d = pend_wr_q + ptr_t'(1);
      end
      if (imem_rsp_valid) begin
        if (drop_cnt_q != '0) begin
          drop_cnt_d = drop_cnt_q - cnt_t'(1);
        end else begin
          pend_rd_d = pend_rd_q + ptr_t'(1);
          fifo_wr_d = fifo_wr_q + ptr_t'(1);
        end
      end
      if (if_pop) begin
        fifo_rd_d = fifo_rd_q + ptr_t'(1);
      end
      fifo_count_d = fifo_count_q + cnt_t'(rsp_push) - cnt_t'(if_pop);
      in_flight_d  = in_flight_q + cnt_t'(req_fire) - rsp_dec;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q         <= RESET_PC;
      pend_wr_q    <= '0;
      pend_rd_q    <= '0;
      fifo_wr_q    <= '0;
      fifo_rd_q    <= '0;
      fifo_count_q <= '0;
      in_flight_q  <= '0;
      drop_cnt_q   <= '0;
    end else begin
      pc_q         <= pc_d;
      pend_wr_q    <= pend_wr_d;
      pend_rd_q    <= pend_rd_d;
      fifo_wr_q    <= fifo_wr_d;
      fifo_rd_q    <= fifo_rd_d;
      fifo_count_q <= fifo_count_d;
      in_flight_q  <= in_flight_d;
      drop_cnt_q   <= drop_cnt_d;
    end
  end

  // Storage arrays carry data only; validity lives in the pointers and counts.
  always_ff @(posedge clk) begin
    if (req_fire) begin
      pend_pc_q[pend_wr_q] <= pc_q;
    end
    if (rsp_push) begin
      fifo_pc_q[fifo_wr_q]    <= pend_pc_q[pend_rd_q];
      fifo_instr_q[fifo_wr_q] <= imem_rsp_data;
    end
  end

  // A kept response can never find the buffer full while credits are respected.
  assert property (@(posedge clk) disable iff (rst)
    (imem_rsp_valid && !redirect_valid && (drop_cnt_q == '0)) |-> (fifo_count_q != cnt_t'(DEPTH)));

endmodule

// File: tb/tb_fetch_unit.sv
// Randomized bench for fetch_unit: a queue-based memory and expected-stream model
// predicts every output each cycle.
module tb_fetch_unit;

  localparam int unsigned DEPTH    = 2;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam logic [31:0] WRAP_PC  = 32'hFFFF_FFF8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst = 1'b1;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        imem_req_valid;
  logic        imem_req_ready = 1'b0;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid = 1'b0;
  logic [31:0] imem_rsp_data = '0;
  logic        if_valid;
  logic        if_ready = 1'b0;
  logic [31:0] if_pc;
  logic [31:0] if_instr;

  fetch_unit #(.RESET_PC(RESET_PC), .DEPTH(DEPTH)) dut (
    .clk            (clk),
    .rst            (rst),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .if_valid       (if_valid),
    .if_ready       (if_ready),
    .if_pc          (if_pc),
    .if_instr       (if_instr)
  );

  logic        w_rst = 1'b1;
  logic        w_req_valid;
  logic [31:0] w_req_addr;
  logic        w_rsp_valid = 1'b0;
  logic [31:0] w_rsp_data = '0;
  logic        w_if_valid;
  logic [31:0] w_if_pc;
  logic [31:0] w_if_instr;

  fetch_unit #(.RESET_PC(WRAP_PC), .DEPTH(DEPTH)) dut_wrap (
    .clk            (clk),
    .rst            (w_rst),
    .redirect_valid (1'b0),
    .redirect_pc    (32'h0),
    .imem_req_valid (w_req_valid),
    .imem_req_ready (1'b1),
    .imem_req_addr  (w_req_addr),
    .imem_rsp_valid (w_rsp_valid),
    .imem_rsp_data  (w_rsp_data),
    .if_valid       (w_if_valid),
    .if_ready       (1'b1),
    .if_pc          (w_if_pc),
    .if_instr       (w_if_instr)
  );

  int checks = 0;
  int passed = 0;
  int cyc = 0;
  bit checks_on = 1'b0;

  // Memory: accepted requests in order, each with a due cycle and a wrong-path mark.
  logic [31:0] mq_addr [$];
  int          mq_due  [$];
  bit          mq_stale[$];
  // Instructions decode should see, in order (identified by PC).
  logic [31:0] mf_pc   [$];
  logic [31:0] exp_req_addr = RESET_PC;

  int lat_min = 1, lat_max = 1, ready_pct = 100, ifrdy_pct = 100;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) passed++;
    else $error("FAIL %s: got %08h expected %08h", tag, got, exp);
  endtask

  // One cycle: drive inputs at posedge+1, compare outputs at negedge, then advance the model.
  task automatic step(input bit redir, input logic [31:0] tgt);
    bit          rsp, exp_valid, exp_req, pop, fire, st;
    logic [31:0] a;
    rsp            = !rst && (mq_addr.size() > 0) && (mq_due[0] <= cyc);
    imem_rsp_valid = rsp;
    imem_rsp_data  = rsp ? mem_word(mq_addr[0]) : $urandom;
    imem_req_ready = ($urandom_range(99) < ready_pct);
    if_ready       = ($urandom_range(99) < ifrdy_pct);
    redirect_valid = redir;
    redirect_pc    = redir ? tgt : $urandom;
    @(negedge clk);
    exp_valid = (mf_pc.size() != 0);
    exp_req   = !rst && !redir && ((mq_addr.size() + mf_pc.size()) < DEPTH);
    if (checks_on) begin
      check("if_valid", 32'(if_valid), 32'(exp_valid));
      check("if_pc", if_pc, exp_valid ? mf_pc[0] : 32'h0);
      check("if_instr", if_instr, exp_valid ? mem_word(mf_pc[0]) : 32'h0);
      check("imem_req_valid", 32'(imem_req_valid), 32'(exp_req));
      if (exp_req) check("imem_req_addr", imem_req_addr, exp_req_addr);
    end
    pop  = exp_valid && if_ready;
    fire = exp_req && imem_req_ready;
    if (rst) begin
      mq_addr.delete(); mq_due.delete(); mq_stale.delete(); mf_pc.delete();
      exp_req_addr = RESET_PC;
    end else begin
      if (pop) void'(mf_pc.pop_front());
      if (rsp) begin
        a = mq_addr.pop_front();
        void'(mq_due.pop_front());
        st = mq_stale.pop_front();
        if (!st && !redir) mf_pc.push_back(a);
      end
      if (redir) begin
        foreach (mq_stale[i]) mq_stale[i] = 1'b1;
        mf_pc.delete();
        exp_req_addr = {tgt[31:2], 2'b00};
      end else if (fire) begin
        mq_addr.push_back(exp_req_addr);
        mq_due.push_back(cyc + int'($urandom_range(lat_max, lat_min)));
        mq_stale.push_back(1'b0);
        exp_req_addr = exp_req_addr + 32'd4;
      end
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic wait_valid(input string tag, input logic [31:0] exp_pc);
    for (int i = 0; i < 30 && !if_valid; i++) step(1'b0, 32'h0);
    check({tag, "_seen"}, 32'(if_valid), 32'h1);
    check(tag, if_pc, exp_pc);
  endtask

  initial begin
    logic [31:0] exp_wrap [3];
    logic [31:0] got_pc   [3];
    logic [31:0] got_ins  [3];
    logic        w_pend;
    logic [31:0] w_pend_addr;
    int          got;
    bit          hit;

    // Wrap-around instance: latency-1 memory, decode always ready.
    exp_wrap = '{32'hFFFF_FFF8, 32'hFFFF_FFFC, 32'h0000_0000};
    @(posedge clk); #1;
    @(posedge clk); #1;
    w_rst  = 1'b0;
    w_pend = 1'b0;
    w_pend_addr = '0;
    got = 0;
    for (int i = 0; i < 20 && got < 3; i++) begin
      w_rsp_valid = w_pend;
      w_rsp_data  = mem_word(w_pend_addr);
      @(negedge clk);
      if (w_if_valid) begin
        got_pc[got]  = w_if_pc;
        got_ins[got] = w_if_instr;
        got++;
      end
      w_pend      = w_req_valid;
      w_pend_addr = w_req_addr;
      @(posedge clk); #1;
    end
    w_rsp_valid = 1'b0;
    w_rst = 1'b1;
    check("wrap_count", got, 3);
    for (int i = 0; i < got; i++) begin
      check("wrap_pc", got_pc[i], exp_wrap[i]);
      check("wrap_instr", got_ins[i], mem_word(exp_wrap[i]));
    end

    // Reset state.
    rst = 1'b1;
    step(1'b0, 32'h0);
    checks_on = 1'b1;
    step(1'b0, 32'h0);
    check("reset_addr", imem_req_addr, RESET_PC);
    step(1'b0, 32'h0);
    rst = 1'b0;

    // Latency 1, decode always ready.
    for (int i = 0; i < 20; i++) step(1'b0, 32'h0);

    // Decode stalls: credits must stop requests, then drain in order.
    ifrdy_pct = 0;
    for (int i = 0; i < 10; i++) step(1'b0, 32'h0);
    ifrdy_pct = 100;
    for (int i = 0; i < 10; i++) step(1'b0, 32'h0);

    // Latency 3, redirect to 0x100 with two requests outstanding.
    lat_min = 3; lat_max = 3;
    for (int i = 0; i < 20 && mq_addr.size() != 2; i++) step(1'b0, 32'h0);
    check("two_in_flight", mq_addr.size(), 2);
    step(1'b1, 32'h0000_0100);
    check("redirect_flush", 32'(if_valid), 32'h0);
    wait_valid("redirect_target", 32'h0000_0100);
    for (int i = 0; i < 12; i++) step(1'b0, 32'h0);

    // Redirect coinciding with a response and a decode pop.
    lat_min = 1; lat_max = 1;
    hit = 1'b0;
    for (int i = 0; i < 40 && !hit; i++) begin
      if (mq_addr.size() > 0 && mq_due[0] <= cyc && mf_pc.size() != 0) begin
        step(1'b1, 32'h0000_0300);
        hit = 1'b1;
      end else begin
        step(1'b0, 32'h0);
      end
    end
    check("same_cycle_redirect_hit", 32'(hit), 32'h1);
    wait_valid("same_cycle_target", 32'h0000_0300);

    // Unaligned target and PC wrap through zero.
    step(1'b1, 32'h0000_0203);
    check("redirect_align", imem_req_addr, 32'h0000_0200);
    wait_valid("aligned_target", 32'h0000_0200);
    step(1'b1, 32'hFFFF_FFF8);
    for (int i = 0; i < 12; i++) step(1'b0, 32'h0);

    // Reset with the buffer full.
    ifrdy_pct = 0;
    for (int i = 0; i < 20 && mf_pc.size() != DEPTH; i++) step(1'b0, 32'h0);
    check("fifo_full_reached", mf_pc.size(), DEPTH);
    rst = 1'b1;
    step(1'b0, 32'h0);
    rst = 1'b0;
    check("reset_clears_valid", 32'(if_valid), 32'h0);
    ifrdy_pct = 100;
    wait_valid("restart_pc", RESET_PC);

    // Random traffic with occasional redirects.
    for (int blk = 0; blk < 16; blk++) begin
      lat_min   = int'($urandom_range(3, 1));
      lat_max   = lat_min + int'($urandom_range(2, 0));
      ready_pct = int'($urandom_range(100, 30));
      ifrdy_pct = int'($urandom_range(100, 20));
      for (int i = 0; i < 50; i++) step($urandom_range(99) < 4, $urandom);
    end

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
